// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus the uart_tx busy line.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] data;
    logic [N_REQ-1:0]   last;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         tx_data;
    logic               tx_send;
    logic               tx_busy;

    modport slave (
        input  req, data, last, tx_busy,
        output ack, grant, tx_data, tx_send
    );

    modport master (
        output req, data, last, tx_busy,
        input  ack, grant, tx_data, tx_send
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locking arbiter sharing one uart_tx between N_REQ byte streams.
// Optional HOLD-state watchdog: define TXARB_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned WDOG_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic               active,
    output logic               wdog_flag
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, HOLD} state_t;

    state_t             state;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   rr_ptr;
    logic               last_q;
    logic [1:0]         wait_cnt;

    logic [PTR_W-1:0]   winner;
    logic [N_REQ-1:0]   win_1h;
    logic [7:0]         win_byte;
    logic               win_last;
    logic [7:0]         own_byte;
    logic               own_last;
    logic               own_req;

    // Invalid configurations elaborate an empty marker block.
    if (N_REQ < 2 || WDOG_CYCLES < 2) begin : g_cfg_invalid
    end

`ifdef TXARB_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
    logic [WDOG_W-1:0] wdog_cnt;
`else
    assign wdog_flag = 1'b0;
`endif

    // Circular search starting at rr_ptr+1.
    always_comb begin
        int unsigned tgt;
        logic        found;
        winner = rr_ptr;
        found  = 1'b0;
        tgt    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            tgt = (32'(rr_ptr) + k) % N_REQ;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && bus.req[i] && (tgt == i)) begin
                    winner = PTR_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    assign win_1h = N_REQ'(1) << winner;

    // Byte, last and req muxes for the search winner and the current owner.
    always_comb begin
        win_byte = 8'h00;
        win_last = 1'b0;
        own_byte = 8'h00;
        own_last = 1'b0;
        own_req  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == winner) begin
                win_byte = bus.data[8*i +: 8];
                win_last = bus.last[i];
            end
            if (PTR_W'(i) == owner) begin
                own_byte = bus.data[8*i +: 8];
                own_last = bus.last[i];
                own_req  = bus.req[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            last_q      <= 1'b0;
            wait_cnt    <= 2'd0;
            bus.grant   <= '0;
            bus.ack     <= '0;
            bus.tx_send <= 1'b0;
            bus.tx_data <= 8'h00;
            active      <= 1'b0;
`ifdef TXARB_WATCHDOG_EN
            wdog_cnt    <= '0;
            wdog_flag   <= 1'b0;
`endif
        end else begin
            bus.ack     <= '0;
            bus.tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req && !bus.tx_busy) begin
                        owner       <= winner;
                        bus.grant   <= win_1h;
                        bus.ack     <= win_1h;
                        bus.tx_send <= 1'b1;
                        bus.tx_data <= win_byte;
                        last_q      <= win_last;
                        active      <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    wait_cnt <= 2'd0;
                    state    <= WAIT_HI;
                end
                // Give up on a busy edge that never shows after three cycles.
                WAIT_HI: begin
                    if (bus.tx_busy || wait_cnt == 2'd2) begin
                        state <= WAIT_LO;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            bus.grant <= '0;
                            rr_ptr    <= owner;
                            active    <= 1'b0;
                            state     <= IDLE;
                        end else if (own_req) begin
                            bus.ack     <= bus.grant;
                            bus.tx_send <= 1'b1;
                            bus.tx_data <= own_byte;
                            last_q      <= own_last;
                            state       <= LOAD;
                        end else begin
`ifdef TXARB_WATCHDOG_EN
                            wdog_cnt <= '0;
`endif
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (own_req && !bus.tx_busy) begin
                        bus.ack     <= bus.grant;
                        bus.tx_send <= 1'b1;
                        bus.tx_data <= own_byte;
                        last_q      <= own_last;
                        state       <= LOAD;
`ifdef TXARB_WATCHDOG_EN
                    end else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                        bus.grant <= '0;
                        rr_ptr    <= owner;
                        active    <= 1'b0;
                        wdog_flag <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
`endif
                    end
                end
                default: begin
                    bus.grant <= '0;
                    active    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a uart_tx busy model (busy 1 cycle after send, 10 cycles long).
module tb_uart_tx_arbiter;
    logic clk;
    logic rst_n;
    logic active;
    logic wdog_flag;
    logic model_en;
    int   busy_cnt;

    uart_tx_arbiter_if #(.N_REQ(2)) bus();

    uart_tx_arbiter #(.N_REQ(2), .WDOG_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .active    (active),
        .wdog_flag (wdog_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_busy <= 1'b0;
            busy_cnt    <= 0;
        end else if (bus.tx_send && model_en) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= 9;
        end else if (bus.tx_busy) begin
            if (busy_cnt == 0) bus.tx_busy <= 1'b0;
            else               busy_cnt    <= busy_cnt - 1;
        end
    end

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];
    int   n_checks;
    int   n_fail;
    int   n_sends;
    int   acks[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge, check invariants, record traffic.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            check("inv_grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
            check("inv_ack_with_send", 32'(bus.ack), bus.tx_send ? 32'(bus.grant) : 32'd0);
            check("inv_no_send_busy", 32'(bus.tx_send && bus.tx_busy), 32'd0);
            check("inv_active_grant", 32'(active), 32'(|bus.grant));
            if (bus.tx_send) n_sends++;
            if (bus.ack[0]) acks[0]++;
            if (bus.ack[1]) acks[1]++;
        end
    endtask

    task automatic wait_send(input int budget, input string name, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.tx_send && cyc < budget);
        check({name, "_sent"}, 32'(bus.tx_send), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.tx_busy !== lvl && n < budget);
        check({name, "_busy_level"}, 32'(bus.tx_busy), 32'(lvl));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (active && n < budget);
        check({name, "_idle"}, 32'(active), 32'd0);
    endtask

    initial begin
        int cyc;
        int sends_before;
        n_checks = 0;
        n_fail   = 0;
        n_sends  = 0;
        acks[0]  = 0;
        acks[1]  = 0;

        vecs[0] = '{2'b11, 8'h10, 8'h80, 2'b01, 8'h10};
        vecs[1] = '{2'b11, 8'h11, 8'h81, 2'b10, 8'h81};
        vecs[2] = '{2'b01, 8'h12, 8'h82, 2'b01, 8'h12};
        vecs[3] = '{2'b10, 8'h13, 8'h83, 2'b10, 8'h83};
        vecs[4] = '{2'b10, 8'h14, 8'h84, 2'b10, 8'h84};
        vecs[5] = '{2'b01, 8'h15, 8'h85, 2'b01, 8'h15};
        vecs[6] = '{2'b01, 8'h16, 8'h86, 2'b01, 8'h16};
        vecs[7] = '{2'b11, 8'h17, 8'h87, 2'b10, 8'h87};

        rst_n    = 1'b0;
        model_en = 1'b1;
        bus.req  = 2'b00;
        bus.last = 2'b00;
        bus.data = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_send", 32'(bus.tx_send), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_wdog", 32'(wdog_flag), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Simultaneous requests right after reset: requester 0 first.
        bus.req  = 2'b11;
        bus.last = 2'b11;
        bus.data = {8'h3C, 8'hA5};
        wait_send(5, "t1_first", cyc);
        check("t1_latency", 32'(cyc), 32'd1);
        check("t1_first_grant", 32'(bus.grant), 32'h1);
        check("t1_first_data", 32'(bus.tx_data), 32'hA5);
        bus.req[0] = 1'b0;
        wait_send(40, "t1_second", cyc);
        check("t1_second_grant", 32'(bus.grant), 32'h2);
        check("t1_second_data", 32'(bus.tx_data), 32'h3C);
        bus.req = 2'b00;
        wait_idle(40, "t1");
        check("t1_acks0", 32'(acks[0]), 32'd1);
        check("t1_acks1", 32'(acks[1]), 32'd1);

        // Single-byte frames: round-robin order from the vector table.
        for (int v = 0; v < 8; v++) begin
            bus.req  = vecs[v].req;
            bus.last = 2'b11;
            bus.data = {vecs[v].d1, vecs[v].d0};
            wait_send(40, $sformatf("vec%0d", v), cyc);
            check($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'(vecs[v].exp_grant));
            check($sformatf("vec%0d_data", v), 32'(bus.tx_data), 32'(vecs[v].exp_data));
            bus.req = 2'b00;
            wait_idle(40, $sformatf("vec%0d", v));
        end

        // 40-byte frame from requester 1; requester 0 joins mid-frame and must wait.
        bus.req  = 2'b10;
        bus.last = 2'b00;
        bus.data = {8'd1, 8'h00};
        for (int b = 1; b <= 40; b++) begin
            wait_send(40, $sformatf("t2_b%0d", b), cyc);
            check($sformatf("t2_b%0d_grant", b), 32'(bus.grant), 32'h2);
            check($sformatf("t2_b%0d_data", b), 32'(bus.tx_data), 32'(b));
            if (b < 40) begin
                bus.data[15:8] = 8'(b + 1);
                bus.last[1]    = (b + 1 == 40);
            end else begin
                bus.req[1] = 1'b0;
            end
            if (b == 5) begin
                bus.req[0]     = 1'b1;
                bus.data[7:0]  = 8'h77;
                bus.last[0]    = 1'b1;
            end
        end
        wait_send(40, "t2_req0", cyc);
        check("t2_req0_grant", 32'(bus.grant), 32'h1);
        check("t2_req0_data", 32'(bus.tx_data), 32'h77);
        bus.req = 2'b00;
        wait_idle(40, "t2");

        // Back-to-back bytes: next send one cycle after busy falls.
        bus.req  = 2'b01;
        bus.last = 2'b00;
        bus.data = {8'h00, 8'hC1};
        wait_send(5, "t3_b1", cyc);
        check("t3_b1_data", 32'(bus.tx_data), 32'hC1);
        bus.data[7:0] = 8'hC2;
        wait_busy(1'b1, 5, "t3_b1_hi");
        wait_busy(1'b0, 20, "t3_b1_lo");
        wait_send(10, "t3_b2", cyc);
        check("t3_b2_gap", 32'(cyc), 32'd1);
        check("t3_b2_data", 32'(bus.tx_data), 32'hC2);
        bus.data[7:0] = 8'hC3;
        bus.last[0]   = 1'b1;
        wait_busy(1'b1, 5, "t3_b2_hi");
        wait_busy(1'b0, 20, "t3_b2_lo");
        wait_send(10, "t3_b3", cyc);
        check("t3_b3_gap", 32'(cyc), 32'd1);
        check("t3_b3_data", 32'(bus.tx_data), 32'hC3);
        bus.req = 2'b00;
        wait_idle(40, "t3");

        // Reset while waiting for busy to fall; outputs clear without a clock edge.
        bus.req  = 2'b10;
        bus.last = 2'b00;
        bus.data = {8'h5A, 8'h00};
        wait_send(5, "t4_pre", cyc);
        check("t4_pre_grant", 32'(bus.grant), 32'h2);
        wait_busy(1'b1, 5, "t4_hi");
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_grant", 32'(bus.grant), 32'd0);
        check("t4_rst_ack", 32'(bus.ack), 32'd0);
        check("t4_rst_send", 32'(bus.tx_send), 32'd0);
        check("t4_rst_active", 32'(active), 32'd0);
        check("t4_rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("t4_rst_wdog", 32'(wdog_flag), 32'd0);
        bus.req  = 2'b11;
        bus.last = 2'b11;
        bus.data = {8'hE2, 8'hE1};
        tick();
        rst_n = 1'b1;
        wait_send(5, "t4_post", cyc);
        check("t4_post_grant", 32'(bus.grant), 32'h1);
        check("t4_post_data", 32'(bus.tx_data), 32'hE1);
        bus.req[0] = 1'b0;
        wait_send(40, "t4_req1", cyc);
        check("t4_req1_grant", 32'(bus.grant), 32'h2);
        check("t4_req1_data", 32'(bus.tx_data), 32'hE2);
        bus.req = 2'b00;
        wait_idle(40, "t4");

        // Owner stalls after a non-last byte while requester 1 waits.
        bus.req  = 2'b01;
        bus.last = 2'b00;
        bus.data = {8'h00, 8'h11};
        wait_send(5, "t5_b1", cyc);
        check("t5_b1_grant", 32'(bus.grant), 32'h1);
        bus.req  = 2'b10;
        bus.last = 2'b10;
        bus.data = {8'h22, 8'h11};
        wait_busy(1'b1, 5, "t5_hi");
        wait_busy(1'b0, 20, "t5_lo");
`ifdef TXARB_WATCHDOG_EN
        wait_send(100, "t5_wdog", cyc);
        check("t5_wdog_latency", 32'(cyc), 32'd18);
        check("t5_wdog_grant", 32'(bus.grant), 32'h2);
        check("t5_wdog_data", 32'(bus.tx_data), 32'h22);
        check("t5_wdog_flag", 32'(wdog_flag), 32'd1);
        bus.req = 2'b00;
        wait_idle(40, "t5");
        check("t5_wdog_sticky", 32'(wdog_flag), 32'd1);
`else
        sends_before = n_sends;
        for (int i = 0; i < 1000; i++) tick();
        check("t5_hold_no_send", 32'(n_sends - sends_before), 32'd0);
        check("t5_hold_grant", 32'(bus.grant), 32'h1);
        check("t5_hold_active", 32'(active), 32'd1);
        check("t5_hold_wdog", 32'(wdog_flag), 32'd0);
        bus.req  = 2'b11;
        bus.last = 2'b11;
        bus.data = {8'h22, 8'h33};
        wait_send(5, "t5_resume", cyc);
        check("t5_resume_latency", 32'(cyc), 32'd1);
        check("t5_resume_grant", 32'(bus.grant), 32'h1);
        check("t5_resume_data", 32'(bus.tx_data), 32'h33);
        bus.req[0] = 1'b0;
        wait_send(40, "t5_req1", cyc);
        check("t5_req1_grant", 32'(bus.grant), 32'h2);
        check("t5_req1_data", 32'(bus.tx_data), 32'h22);
        bus.req = 2'b00;
        wait_idle(40, "t5");
        check("t5_wdog_off", 32'(wdog_flag), 32'd0);
`endif

        // Transmitter that never raises busy: WAIT_HI times out after three cycles.
        model_en = 1'b0;
        bus.req  = 2'b01;
        bus.last = 2'b00;
        bus.data = {8'h00, 8'h61};
        wait_send(5, "t6_b1", cyc);
        check("t6_b1_data", 32'(bus.tx_data), 32'h61);
        bus.data[7:0] = 8'h62;
        bus.last[0]   = 1'b1;
        wait_send(20, "t6_b2", cyc);
        check("t6_b2_gap", 32'(cyc), 32'd5);
        check("t6_b2_data", 32'(bus.tx_data), 32'h62);
        bus.req = 2'b00;
        wait_idle(20, "t6");
        model_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
